pll_ctrl: RTL and testbench

//  Sequences the ECP5 EHXPLLL: pulses PLL reset, qualifies LOCK, releases a synchronous system reset and recovers on lock loss.

---
 rtl/pll_ctrl_pkg.sv | 28 ++
 rtl/pll_lock_filter.sv | 46 ++++
 rtl/pll_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_pll_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_ctrl_pkg.sv
// Shared types and widths for the ECP5 PLL controller.
//   state_t  : controller states (PLL reset, lock wait, run, phase-step phases)
//   STEPS_W  : width of a phase-step request count
//   RETRY_W  : width of the saturating PLL reset-attempt counter
package pll_ctrl_pkg;

  localparam int STEPS_W = 8;
  localparam int RETRY_W = 4;

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    RUN,
    PH_SETUP,
    PH_LOW,
    PH_GAP
  } state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [RETRY_W-1:0] sat_inc(input logic [RETRY_W-1:0] r);
    return (r == '1) ? r : r + 1'b1;
  endfunction

endpackage

// File: rtl/pll_lock_filter.sv
// Lock qualifier for the PLL LOCK output.
//   clk, reset  : reference clock, synchronous active-high reset
//   pll_locked  : raw asynchronous LOCK from the PLL
//   enable      : high while the controller waits for lock; low clears the count
//   lock_s      : LOCK after a 2-flop synchroniser
//   lock_ok     : high on the edge where the stable count reaches LOCK_STABLE
module pll_lock_filter #(
  parameter int LOCK_STABLE = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic pll_locked,
  input  logic enable,
  output logic lock_s,
  output logic lock_ok
);

  localparam int CW = $clog2(LOCK_STABLE + 1);

  logic          sync1;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values; blocking here would collapse the synchroniser.
    if (reset) begin
      sync1  <= 1'b0;
      lock_s <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1  <= pll_locked;
      lock_s <= sync1;
      if (enable && lock_s) begin
        if (cnt != CW'(LOCK_STABLE))
          cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
    end
  end

  // Asserted when this edge's sample of lock_s is the LOCK_STABLE-th
  // consecutive high one, so the FSM leaves WAIT_LOCK on that same edge.
  assign lock_ok = enable && lock_s && (cnt == CW'(LOCK_STABLE - 1));

endmodule

// File: rtl/pll_ctrl.sv
// ECP5 EHXPLLL sequencer: pulses the PLL reset, qualifies LOCK, releases a
// synchronous system reset, recovers from lock loss, and runs dynamic phase
// adjustment requests.
//   clk, reset      : reference clock, synchronous active-high reset
//   pll_locked      : raw PLL LOCK (asynchronous)
//   pll_rst         : PLL RST
//   phase_sel/dir   : PHASESEL[1:0] / PHASEDIR
//   phase_step      : PHASESTEP, idle high, pulsed low per step
//   phase_loadreg   : PHASELOADREG, tied high
//   rst_out         : system reset, active-high
//   ph_valid/ready  : phase request handshake (ready only in RUN with lock)
//   ph_sel/dir/steps: request fields; steps==0 completes immediately
//   ph_done/ph_err  : one-cycle completion pulse; err=1 means aborted by lock loss
//   retries         : PLL reset attempts since reset, saturating
module pll_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_STABLE  = 1024,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int STEP_SETUP   = 4,
  parameter int STEP_LOW     = 4,
  parameter int STEP_GAP     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pll_locked,
  output logic               pll_rst,
  output logic [1:0]         phase_sel,
  output logic               phase_dir,
  output logic               phase_step,
  output logic               phase_loadreg,
  output logic               rst_out,
  input  logic               ph_valid,
  output logic               ph_ready,
  input  logic [1:0]         ph_sel,
  input  logic               ph_dir,
  input  logic [STEPS_W-1:0] ph_steps,
  output logic               ph_done,
  output logic               ph_err,
  output logic [RETRY_W-1:0] retries
);

  localparam int CNT_MAX = max2(max2(RST_CYCLES, LOCK_TIMEOUT),
                                max2(max2(STEP_SETUP, STEP_LOW), STEP_GAP));
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [STEPS_W-1:0] remaining;
  logic               lock_s;
  logic               lock_ok;
  logic               accept;
  logic               in_flight;
  logic               lock_lost;

  // Terminal count for a phase lasting n cycles.
  function automatic logic [CNT_W-1:0] term(input int n);
    return CNT_W'(n - 1);
  endfunction

  pll_lock_filter #(.LOCK_STABLE(LOCK_STABLE)) u_lock_filter (
    .clk        (clk),
    .reset      (reset),
    .pll_locked (pll_locked),
    .enable     (state == WAIT_LOCK),
    .lock_s     (lock_s),
    .lock_ok    (lock_ok)
  );

  assign phase_loadreg = 1'b1;
  // Combinational gating with lock_s so lock loss beats acceptance.
  assign ph_ready  = (state == RUN) && lock_s;
  assign accept    = ph_valid && ph_ready;
  assign in_flight = (state == PH_SETUP) || (state == PH_LOW) || (state == PH_GAP);
  assign lock_lost = !lock_s && ((state == RUN) || in_flight);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= PLL_RST;
      cnt        <= '0;
      remaining  <= '0;
      pll_rst    <= 1'b1;
      rst_out    <= 1'b1;
      phase_step <= 1'b1;
      phase_sel  <= 2'd0;
      phase_dir  <= 1'b0;
      ph_done    <= 1'b0;
      ph_err     <= 1'b0;
      retries    <= '0;
    end else begin
      ph_done <= 1'b0;
      ph_err  <= 1'b0;
      if (lock_lost) begin
        state      <= PLL_RST;
        cnt        <= '0;
        pll_rst    <= 1'b1;
        rst_out    <= 1'b1;
        phase_step <= 1'b1;
        retries    <= sat_inc(retries);
        if (in_flight) begin
          ph_done <= 1'b1;
          ph_err  <= 1'b1;
        end
      end else begin
        case (state)
          PLL_RST: begin
            if (cnt == term(RST_CYCLES)) begin
              state   <= WAIT_LOCK;
              cnt     <= '0;
              pll_rst <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          WAIT_LOCK: begin
            if (lock_ok) begin
              state   <= RUN;
              cnt     <= '0;
              rst_out <= 1'b0;
            end else if (cnt == term(LOCK_TIMEOUT)) begin
              state   <= PLL_RST;
              cnt     <= '0;
              pll_rst <= 1'b1;
              retries <= sat_inc(retries);
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          RUN: begin
            if (accept) begin
              if (ph_steps == '0) begin
                ph_done <= 1'b1;
              end else begin
                // phase_sel/phase_dir act as the request latch; they only
                // change here, on entry to PH_SETUP.
                state     <= PH_SETUP;
                cnt       <= '0;
                remaining <= ph_steps;
                phase_sel <= ph_sel;
                phase_dir <= ph_dir;
              end
            end
          end
          PH_SETUP: begin
            if (cnt == term(STEP_SETUP)) begin
              state      <= PH_LOW;
              cnt        <= '0;
              phase_step <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          PH_LOW: begin
            if (cnt == term(STEP_LOW)) begin
              state      <= PH_GAP;
              cnt        <= '0;
              phase_step <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          PH_GAP: begin
            if (cnt == term(STEP_GAP)) begin
              cnt <= '0;
              if (remaining == STEPS_W'(1)) begin
                state     <= RUN;
                remaining <= '0;
                ph_done   <= 1'b1;
              end else begin
                state     <= PH_SETUP;
                remaining <= remaining - 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= PLL_RST;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pll_ctrl.sv
// Directed bench for pll_ctrl with small parameters
// (RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=64, STEP_*=2).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_pll_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       pll_locked;
  logic       pll_rst;
  logic [1:0] phase_sel;
  logic       phase_dir;
  logic       phase_step;
  logic       phase_loadreg;
  logic       rst_out;
  logic       ph_valid;
  logic       ph_ready;
  logic [1:0] ph_sel;
  logic       ph_dir;
  logic [7:0] ph_steps;
  logic       ph_done;
  logic       ph_err;
  logic [3:0] retries;

  int tests_run    = 0;
  int tests_failed = 0;

  // Trace results shared by the sequence tests.
  int   falls[$];
  int   low_total, done_idx, done_cnt, ready_bad, sel_bad;
  logic err_at_done;

  always #5 clk = ~clk;

  pll_ctrl #(
    .RST_CYCLES   (4),
    .LOCK_STABLE  (8),
    .LOCK_TIMEOUT (64),
    .STEP_SETUP   (2),
    .STEP_LOW     (2),
    .STEP_GAP     (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pll_locked    (pll_locked),
    .pll_rst       (pll_rst),
    .phase_sel     (phase_sel),
    .phase_dir     (phase_dir),
    .phase_step    (phase_step),
    .phase_loadreg (phase_loadreg),
    .rst_out       (rst_out),
    .ph_valid      (ph_valid),
    .ph_ready      (ph_ready),
    .ph_sel        (ph_sel),
    .ph_dir        (ph_dir),
    .ph_steps      (ph_steps),
    .ph_done       (ph_done),
    .ph_err        (ph_err),
    .retries       (retries)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge, then withdraw it.
  task automatic request(input logic [1:0] s, input logic d, input logic [7:0] n);
    ph_sel   = s;
    ph_dir   = d;
    ph_steps = n;
    ph_valid = 1'b1;
    tick();
    ph_valid = 1'b0;
  endtask

  // Sample n cycles (index 0 = now) and summarise phase_step/ph_done activity.
  task automatic trace(input int n, input logic [1:0] esel, input logic edir);
    logic prev;
    prev = 1'b1;
    falls.delete();
    low_total = 0; done_idx = -1; done_cnt = 0; ready_bad = 0; sel_bad = 0;
    err_at_done = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) tick();
      if (phase_step === 1'b0) begin
        low_total++;
        if (prev === 1'b1) falls.push_back(i);
      end
      prev = phase_step;
      if (ph_done === 1'b1) begin
        done_cnt++;
        if (done_idx < 0) begin
          done_idx    = i;
          err_at_done = ph_err;
        end
      end
      if (done_idx < 0 && ph_ready !== 1'b0) ready_bad++;
      if (phase_sel !== esel || phase_dir !== edir) sel_bad++;
    end
  endtask

  task automatic test_reset();
    logic [15:0] got, exp;
    reset      = 1'b1;
    pll_locked = 1'b0;
    ph_valid   = 1'b0;
    ph_sel     = 2'd0;
    ph_dir     = 1'b0;
    ph_steps   = 8'd0;
    tick();
    // {pll_rst,rst_out,phase_step,phase_sel,phase_dir,ph_ready,ph_done,ph_err,retries,phase_loadreg}
    got = {pll_rst, rst_out, phase_step, phase_sel, phase_dir, ph_ready, ph_done, ph_err, retries, phase_loadreg};
    exp = {1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1};
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL reset_values got=%h want=%h", got, exp);
    end
    reset = 1'b0;
    tick(); tick(); tick();
    tests_run++;
    if (pll_rst !== 1'b1) begin
      tests_failed++;
      $display("FAIL pll_rst_held got=%b want=1", pll_rst);
    end
    tick();
    tests_run++;
    if (pll_rst !== 1'b0) begin
      tests_failed++;
      $display("FAIL pll_rst_release got=%b want=0", pll_rst);
    end
  endtask

  // T1: lock rises 10 cycles after pll_rst falls; rst_out falls 2+8 edges later.
  task automatic test_lock_release();
    int n;
    repeat (10) tick();
    pll_locked = 1'b1;
    n = 0;
    while (rst_out !== 1'b0 && n < 40) begin
      tick();
      n++;
    end
    tests_run++;
    if (n !== 10) begin
      tests_failed++;
      $display("FAIL release_latency got=%0d want=10", n);
    end
    tests_run++;
    if ({retries, ph_ready, pll_rst} !== {4'd0, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL run_state retries=%0d ready=%b pll_rst=%b want 0,1,0", retries, ph_ready, pll_rst);
    end
  endtask

  // T3: sel=1 dir=1 steps=3 -> lows at 2,8,14 (2 cycles each), done at 18.
  task automatic test_phase_steps();
    int f0, f1, f2;
    request(2'd1, 1'b1, 8'd3);
    trace(24, 2'd1, 1'b1);
    f0 = (falls.size() > 0) ? falls[0] : -1;
    f1 = (falls.size() > 1) ? falls[1] : -1;
    f2 = (falls.size() > 2) ? falls[2] : -1;
    tests_run++;
    if (falls.size() !== 3 || f0 !== 2 || f1 !== 8 || f2 !== 14) begin
      tests_failed++;
      $display("FAIL step_pulses n=%0d at %0d,%0d,%0d want 3 at 2,8,14", falls.size(), f0, f1, f2);
    end
    tests_run++;
    if (low_total !== 6) begin
      tests_failed++;
      $display("FAIL step_low_cycles got=%0d want=6", low_total);
    end
    tests_run++;
    if (done_idx !== 18 || done_cnt !== 1 || err_at_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL step_done idx=%0d cnt=%0d err=%b want 18,1,0", done_idx, done_cnt, err_at_done);
    end
    tests_run++;
    if (ready_bad !== 0 || sel_bad !== 0) begin
      tests_failed++;
      $display("FAIL step_ready_sel ready_hi=%0d sel_bad=%0d want 0,0", ready_bad, sel_bad);
    end
  endtask

  // T4: steps=0 -> immediate done, no pulses, phase_sel/dir keep previous value.
  task automatic test_zero_steps();
    tests_run++;
    if (ph_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL zero_ready got=%b want=1", ph_ready);
    end
    request(2'd2, 1'b0, 8'd0);
    trace(6, 2'd1, 1'b1);
    tests_run++;
    if (done_idx !== 0 || done_cnt !== 1 || err_at_done !== 1'b0 || low_total !== 0 || sel_bad !== 0) begin
      tests_failed++;
      $display("FAIL zero_steps done=%0d cnt=%0d err=%b low=%0d sel_bad=%0d want 0,1,0,0,0",
               done_idx, done_cnt, err_at_done, low_total, sel_bad);
    end
  endtask

  // T5: lock drops during 2nd PH_LOW -> abort at idx 10, relock releases at idx 22.
  task automatic test_lock_loss();
    int   abort_idx, rel_idx, nfalls, ndone;
    logic prev;
    logic [4:0] at_abort;
    abort_idx = -1; rel_idx = -1; nfalls = 0; ndone = 0; prev = 1'b1;
    at_abort = '0;
    request(2'd2, 1'b0, 8'd3);
    for (int i = 0; i <= 30; i++) begin
      if (i > 0) tick();
      if (phase_step === 1'b0 && prev === 1'b1) nfalls++;
      prev = phase_step;
      if (ph_done === 1'b1) begin
        ndone++;
        if (abort_idx < 0) begin
          abort_idx = i;
          at_abort  = {ph_err, phase_step, rst_out, pll_rst, ph_ready};
        end
      end
      if (abort_idx >= 0 && rel_idx < 0 && rst_out === 1'b0) rel_idx = i;
      if (i == 7)  pll_locked = 1'b0;
      if (i == 10) pll_locked = 1'b1;
    end
    tests_run++;
    if (abort_idx !== 10 || ndone !== 1 || nfalls !== 2) begin
      tests_failed++;
      $display("FAIL abort_timing idx=%0d dones=%0d pulses=%0d want 10,1,2", abort_idx, ndone, nfalls);
    end
    tests_run++;
    if (at_abort !== 5'b11110) begin
      tests_failed++;
      $display("FAIL abort_outputs {err,step,rst_out,pll_rst,ready}=%b want 11110", at_abort);
    end
    tests_run++;
    if (retries !== 4'd1) begin
      tests_failed++;
      $display("FAIL abort_retries got=%0d want=1", retries);
    end
    tests_run++;
    if (rel_idx !== 22) begin
      tests_failed++;
      $display("FAIL relock_release got=%0d want=22", rel_idx);
    end
  endtask

  // T6: reset in PH_GAP -> reset values next cycle, no done, full restart.
  task automatic test_reset_mid_step();
    logic [15:0] got, exp;
    int pr_fall, ro_fall, ndone;
    pr_fall = -1; ro_fall = -1; ndone = 0;
    request(2'd3, 1'b1, 8'd2);
    repeat (4) tick();
    tests_run++;
    if ({phase_step, ph_ready, phase_sel} !== {1'b1, 1'b0, 2'd3}) begin
      tests_failed++;
      $display("FAIL gap_state step=%b ready=%b sel=%0d want 1,0,3", phase_step, ph_ready, phase_sel);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    got = {pll_rst, rst_out, phase_step, phase_sel, phase_dir, ph_ready, ph_done, ph_err, retries, phase_loadreg};
    exp = {1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1};
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL midreset_values got=%h want=%h", got, exp);
    end
    for (int j = 1; j <= 14; j++) begin
      tick();
      if (ph_done === 1'b1) ndone++;
      if (pr_fall < 0 && pll_rst === 1'b0) pr_fall = j;
      if (ro_fall < 0 && rst_out === 1'b0) ro_fall = j;
    end
    tests_run++;
    if (pr_fall !== 4 || ro_fall !== 12 || ndone !== 0) begin
      tests_failed++;
      $display("FAIL midreset_restart pll_rst_fall=%0d rst_out_fall=%0d dones=%0d want 4,12,0",
               pr_fall, ro_fall, ndone);
    end
  endtask

  // T2: no lock -> pll_rst high 4 of every 68 cycles, retries count and stick at 15.
  task automatic test_no_lock();
    int   bad_rst, bad_ret, bad_out, first_bad;
    logic exp_rst;
    int   exp_ret;
    bad_rst = 0; bad_ret = 0; bad_out = 0; first_bad = -1;
    pll_locked = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i <= 17 * 68; i++) begin
      if (i > 0) tick();
      exp_rst = ((i % 68) < 4);
      exp_ret = (i / 68 > 15) ? 15 : i / 68;
      if (pll_rst !== exp_rst) begin
        bad_rst++;
        if (first_bad < 0) first_bad = i;
      end
      if (retries !== 4'(exp_ret)) begin
        bad_ret++;
        if (first_bad < 0) first_bad = i;
      end
      if (rst_out !== 1'b1) bad_out++;
    end
    tests_run++;
    if (bad_rst !== 0) begin
      tests_failed++;
      $display("FAIL retry_period bad_cycles=%0d first_at=%0d want 0", bad_rst, first_bad);
    end
    tests_run++;
    if (bad_ret !== 0) begin
      tests_failed++;
      $display("FAIL retry_count bad_cycles=%0d first_at=%0d want 0", bad_ret, first_bad);
    end
    tests_run++;
    if (retries !== 4'd15 || bad_out !== 0) begin
      tests_failed++;
      $display("FAIL retry_saturate retries=%0d rst_out_low=%0d want 15,0", retries, bad_out);
    end
  endtask

  initial begin
    test_reset();
    test_lock_release();
    test_phase_steps();
    test_zero_steps();
    test_lock_loss();
    test_reset_mid_step();
    test_no_lock();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
